// File: rtl/am_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : am_request_arbiter
// Brief    : Round-robin arbiter that shares one associative memory (AM)
//            among NUM_REQ query sources. One query/result transaction is
//            outstanding at a time: grant -> issue to AM -> wait for result
//            -> respond to the granted requester.
// Revision : 1.0 - initial release
// ============================================================================
module am_request_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int REQ_IDX_WIDTH  = $clog2(NUM_REQ),
    parameter int HV_DIMENSION   = 64,
    parameter int LABEL_WIDTH    = 4,
    parameter int DISTANCE_WIDTH = 7
) (
    input  logic                              Clk_CI,
    input  logic                              Reset_RBI,

    // Requester query side
    input  logic [NUM_REQ-1:0]                ReqValid_SI,
    output logic [NUM_REQ-1:0]                ReqReady_SO,
    input  logic [NUM_REQ*HV_DIMENSION-1:0]   ReqHV_mod1_DI,
    input  logic [NUM_REQ*HV_DIMENSION-1:0]   ReqHV_mod2_DI,
    input  logic [NUM_REQ*HV_DIMENSION-1:0]   ReqHV_mod3_DI,

    // Requester response side
    output logic [NUM_REQ-1:0]                RspValid_SO,
    input  logic [NUM_REQ-1:0]                RspReady_SI,
    output logic [LABEL_WIDTH-1:0]            RspLabel_A_DO,
    output logic [LABEL_WIDTH-1:0]            RspLabel_V_DO,
    output logic [DISTANCE_WIDTH-1:0]         RspDistance_A_DO,
    output logic [DISTANCE_WIDTH-1:0]         RspDistance_V_DO,

    // Status
    output logic [REQ_IDX_WIDTH-1:0]          GrantIdx_DO,
    output logic                              Busy_SO,

    // Associative memory query side
    output logic                              AmValid_SO,
    input  logic                              AmReady_SI,
    output logic [HV_DIMENSION-1:0]           AmHV_mod1_DO,
    output logic [HV_DIMENSION-1:0]           AmHV_mod2_DO,
    output logic [HV_DIMENSION-1:0]           AmHV_mod3_DO,

    // Associative memory result side
    input  logic                              AmValid_SI,
    output logic                              AmReady_SO,
    input  logic [LABEL_WIDTH-1:0]            AmLabel_A_DI,
    input  logic [LABEL_WIDTH-1:0]            AmLabel_V_DI,
    input  logic [DISTANCE_WIDTH-1:0]         AmDistance_A_DI,
    input  logic [DISTANCE_WIDTH-1:0]         AmDistance_V_DI
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    localparam logic [REQ_IDX_WIDTH-1:0] LAST_IDX = REQ_IDX_WIDTH'(NUM_REQ - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                      state_q;
    logic [REQ_IDX_WIDTH-1:0]    ptr_q;
    logic [REQ_IDX_WIDTH-1:0]    grant_q;
    logic [HV_DIMENSION-1:0]     hv1_q;
    logic [HV_DIMENSION-1:0]     hv2_q;
    logic [HV_DIMENSION-1:0]     hv3_q;
    logic [LABEL_WIDTH-1:0]      label_a_q;
    logic [LABEL_WIDTH-1:0]      label_v_q;
    logic [DISTANCE_WIDTH-1:0]   dist_a_q;
    logic [DISTANCE_WIDTH-1:0]   dist_v_q;

    // ------------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------------
    logic                        found_d;
    logic [REQ_IDX_WIDTH-1:0]    winner_d;
    logic [REQ_IDX_WIDTH-1:0]    ptr_d;
    logic [HV_DIMENSION-1:0]     sel_hv1_d;
    logic [HV_DIMENSION-1:0]     sel_hv2_d;
    logic [HV_DIMENSION-1:0]     sel_hv3_d;

    // Modulo-NUM_REQ addition of a small offset to a requester index.
    function automatic logic [REQ_IDX_WIDTH-1:0] wrap_add(
        input logic [REQ_IDX_WIDTH-1:0] base,
        input int                       offs
    );
        int sum;
        sum = int'(base) + offs;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return REQ_IDX_WIDTH'(sum);
    endfunction

    // Round-robin scan: first valid requester at or above the pointer, wrapping
    always_comb begin
        found_d  = 1'b0;
        winner_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_d && ReqValid_SI[wrap_add(ptr_q, k)]) begin
                found_d  = 1'b1;
                winner_d = wrap_add(ptr_q, k);
            end
        end
    end

    // Slice out the winner's three modality hypervectors
    always_comb begin
        sel_hv1_d = ReqHV_mod1_DI[int'(winner_d) * HV_DIMENSION +: HV_DIMENSION];
        sel_hv2_d = ReqHV_mod2_DI[int'(winner_d) * HV_DIMENSION +: HV_DIMENSION];
        sel_hv3_d = ReqHV_mod3_DI[int'(winner_d) * HV_DIMENSION +: HV_DIMENSION];
    end

    // Pointer moves just past the requester that was served, wrapping at the top
    always_comb begin
        ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
    end

    // Transaction sequencer: grant, issue to the AM, collect result, respond.
    // A reset mid-transaction simply drops it; the AM is reset alongside.
    always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
        if (!Reset_RBI) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            hv1_q     <= '0;
            hv2_q     <= '0;
            hv3_q     <= '0;
            label_a_q <= '0;
            label_v_q <= '0;
            dist_a_q  <= '0;
            dist_v_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        grant_q <= winner_d;
                        hv1_q   <= sel_hv1_d;
                        hv2_q   <= sel_hv2_d;
                        hv3_q   <= sel_hv3_d;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (AmReady_SI) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (AmValid_SI) begin
                        label_a_q <= AmLabel_A_DI;
                        label_v_q <= AmLabel_V_DI;
                        dist_a_q  <= AmDistance_A_DI;
                        dist_v_q  <= AmDistance_V_DI;
                        state_q   <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    // Only the granted requester can complete the response
                    if (RspReady_SI[grant_q]) begin
                        ptr_q   <= ptr_d;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Accept strobe to the winner; forced low while reset is asserted
    always_comb begin
        ReqReady_SO = '0;
        if (Reset_RBI && (state_q == ST_IDLE) && found_d) begin
            ReqReady_SO[winner_d] = 1'b1;
        end
    end

    // Response valid addressed to the granted requester only
    always_comb begin
        RspValid_SO = '0;
        if (state_q == ST_RESPOND) begin
            RspValid_SO[grant_q] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State-decoded handshakes and held data
    // ------------------------------------------------------------------------
    assign Busy_SO          = (state_q != ST_IDLE);
    assign AmValid_SO       = (state_q == ST_ISSUE);
    assign AmReady_SO       = (state_q == ST_WAIT);
    assign GrantIdx_DO      = grant_q;
    assign AmHV_mod1_DO     = hv1_q;
    assign AmHV_mod2_DO     = hv2_q;
    assign AmHV_mod3_DO     = hv3_q;
    assign RspLabel_A_DO    = label_a_q;
    assign RspLabel_V_DO    = label_v_q;
    assign RspDistance_A_DO = dist_a_q;
    assign RspDistance_V_DO = dist_v_q;

`ifndef SYNTHESIS
    // Grant and response strobes never address more than one requester
    always_ff @(posedge Clk_CI) begin
        if (Reset_RBI) begin
            assert ($onehot0(ReqReady_SO));
            assert ($onehot0(RspValid_SO));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_am_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_am_request_arbiter
// Brief    : Directed bench for am_request_arbiter with a transaction-level
//            reference model checked every cycle plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_am_request_arbiter;

    localparam int NR  = 3;
    localparam int HVD = 16;
    localparam int LW  = 4;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*HVD-1:0] hv1, hv2, hv3;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [LW-1:0]     label_a, label_v;
    logic [DW-1:0]     dist_a, dist_v;
    logic [1:0]        grant_idx;
    logic              busy;
    logic              am_valid_o;
    logic              am_ready_i;
    logic [HVD-1:0]    am_hv1, am_hv2, am_hv3;
    logic              am_valid_i;
    logic              am_ready_o;
    logic [LW-1:0]     am_la, am_lv;
    logic [DW-1:0]     am_da, am_dv;

    int n_tests = 0;
    int n_fail  = 0;

    am_request_arbiter #(
        .NUM_REQ        (NR),
        .REQ_IDX_WIDTH  (2),
        .HV_DIMENSION   (HVD),
        .LABEL_WIDTH    (LW),
        .DISTANCE_WIDTH (DW)
    ) dut (
        .Clk_CI           (clk),
        .Reset_RBI        (rst_n),
        .ReqValid_SI      (req_valid),
        .ReqReady_SO      (req_ready),
        .ReqHV_mod1_DI    (hv1),
        .ReqHV_mod2_DI    (hv2),
        .ReqHV_mod3_DI    (hv3),
        .RspValid_SO      (rsp_valid),
        .RspReady_SI      (rsp_ready),
        .RspLabel_A_DO    (label_a),
        .RspLabel_V_DO    (label_v),
        .RspDistance_A_DO (dist_a),
        .RspDistance_V_DO (dist_v),
        .GrantIdx_DO      (grant_idx),
        .Busy_SO          (busy),
        .AmValid_SO       (am_valid_o),
        .AmReady_SI       (am_ready_i),
        .AmHV_mod1_DO     (am_hv1),
        .AmHV_mod2_DO     (am_hv2),
        .AmHV_mod3_DO     (am_hv3),
        .AmValid_SI       (am_valid_i),
        .AmReady_SO       (am_ready_o),
        .AmLabel_A_DI     (am_la),
        .AmLabel_V_DI     (am_lv),
        .AmDistance_A_DI  (am_da),
        .AmDistance_V_DI  (am_dv)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model: one in-flight transaction record plus a RR pointer
    // ------------------------------------------------------------------------
    bit             m_active, m_issued, m_done;
    int             m_idx, m_grant, m_ptr;
    logic [HVD-1:0] m_hv1, m_hv2, m_hv3;
    logic [LW-1:0]  m_la, m_lv;
    logic [DW-1:0]  m_da, m_dv;

    function automatic int model_winner();
        for (int k = 0; k < NR; k++) begin
            if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (!rst_n) begin
            m_active = 0; m_issued = 0; m_done = 0;
            m_idx = 0; m_grant = 0; m_ptr = 0;
            m_hv1 = '0; m_hv2 = '0; m_hv3 = '0;
            m_la = '0; m_lv = '0; m_da = '0; m_dv = '0;
        end else if (!m_active) begin
            w = model_winner();
            if (w >= 0) begin
                m_active = 1; m_idx = w; m_grant = w;
                m_hv1 = hv1[w*HVD +: HVD];
                m_hv2 = hv2[w*HVD +: HVD];
                m_hv3 = hv3[w*HVD +: HVD];
            end
        end else if (!m_issued) begin
            if (am_ready_i) m_issued = 1;
        end else if (!m_done) begin
            if (am_valid_i) begin
                m_la = am_la; m_lv = am_lv; m_da = am_da; m_dv = am_dv;
                m_done = 1;
            end
        end else if (rsp_ready[m_idx]) begin
            m_ptr = (m_idx + 1) % NR;
            m_active = 0; m_issued = 0; m_done = 0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NR-1:0] e_req_ready, e_rsp_valid;
        int w;
        e_req_ready = '0;
        e_rsp_valid = '0;
        if (rst_n && !m_active) begin
            w = model_winner();
            if (w >= 0) e_req_ready[w] = 1'b1;
        end
        if (m_active && m_done) e_rsp_valid[m_idx] = 1'b1;
        check("cmp_req_ready", req_ready, e_req_ready);
        check("cmp_rsp_valid", rsp_valid, e_rsp_valid);
        check("cmp_busy", busy, m_active);
        check("cmp_am_valid", am_valid_o, m_active && !m_issued);
        check("cmp_am_ready", am_ready_o, m_active && m_issued && !m_done);
        check("cmp_grant", grant_idx, m_grant);
        check("cmp_am_hv", {am_hv1, am_hv2, am_hv3}, {m_hv1, m_hv2, m_hv3});
        check("cmp_rsp_data", {label_a, label_v, dist_a, dist_v}, {m_la, m_lv, m_da, m_dv});
    endtask

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in ISSUE; leaves it in RESPOND
    task automatic am_transact(input int stall, input int compute,
                               input logic [LW-1:0] la, input logic [LW-1:0] lv,
                               input logic [DW-1:0] da, input logic [DW-1:0] dv);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("am_valid_during_stall", am_valid_o, 1);
        end
        am_ready_i = 1'b1;
        tick();
        am_ready_i = 1'b0;
        for (int c = 0; c < compute; c++) tick();
        am_valid_i = 1'b1;
        am_la = la; am_lv = lv; am_da = da; am_dv = dv;
        tick();
        am_valid_i = 1'b0;
        am_la = ~la; am_lv = ~lv; am_da = ~da; am_dv = ~dv;
    endtask

    int exp_order [6] = '{2, 0, 1, 2, 0, 1};

    // Watchdog
    initial begin
        #20000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b1;
        req_valid = '0; rsp_ready = '0; hv1 = '0; hv2 = '0; hv3 = '0;
        am_ready_i = 0; am_valid_i = 0; am_la = '0; am_lv = '0; am_da = '0; am_dv = '0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_grant", grant_idx, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        tick();

        // 1: single requester with AM stall
        hv1 = {16'h0000, 16'hFFFF, 16'h0000};
        hv2 = {16'h0000, 16'h1234, 16'h0000};
        hv3 = {16'h0000, 16'hABCD, 16'h0000};
        req_valid = 3'b010;
        #1;
        check("t1_req_ready", req_ready, 3'b010);
        tick();
        req_valid = '0; hv1 = '0;
        #1;
        check("t1_req_ready_once", req_ready, 3'b000);
        check("t1_grant", grant_idx, 1);
        check("t1_am_hv1", am_hv1, 16'hFFFF);
        check("t1_am_hv3", am_hv3, 16'hABCD);
        am_transact(5, 0, 4'd1, 4'd2, 8'd37, 8'd50);
        #1;
        check("t1_rsp_valid", rsp_valid, 3'b010);
        check("t1_label_a", label_a, 1);
        check("t1_dist_a", dist_a, 37);
        rsp_ready = 3'b010;
        tick();
        rsp_ready = '0;
        #1;
        check("t1_idle_busy", busy, 0);
        check("t1_label_held", label_a, 1);

        // 2: fairness with all requesters held valid (pointer starts at 2)
        hv1 = 48'h1111_2222_3333; hv2 = 48'h4444_5555_6666; hv3 = 48'h7777_8888_9999;
        req_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin
            #1;
            check("t2_idle_busy", busy, 0);
            check("t2_grant_order", req_ready, 3'b001 << exp_order[t]);
            tick();
            #1;
            check("t2_busy_after_accept", busy, 1);
            am_transact(0, 1, 4'(t), 4'(t + 1), 8'(t * 3), 8'(t * 5));
            rsp_ready = 3'b111;
            if (t == 5) req_valid = '0;
            tick();
            rsp_ready = '0;
        end

        // 3: response backpressure (pointer at 2, only requester 0 valid)
        req_valid = 3'b001;
        #1;
        check("t3_req_ready", req_ready, 3'b001);
        tick();
        req_valid = 3'b100;
        am_transact(0, 0, 4'd5, 4'd6, 8'd200, 8'd3);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t3_rsp_valid_hold", rsp_valid, 3'b001);
            check("t3_dist_hold", dist_a, 200);
            check("t3_no_accept", req_ready, 3'b000);
            tick();
        end
        rsp_ready = 3'b001;
        #1;
        check("t3_no_early_accept", req_ready, 3'b000);
        tick();
        rsp_ready = '0;
        #1;
        check("t3_accept_after", req_ready, 3'b100);
        tick();
        req_valid = '0;

        // 4: wrong-requester ready while responding to index 2
        #1;
        check("t4_grant", grant_idx, 2);
        am_transact(1, 2, 4'd9, 4'd10, 8'd11, 8'd12);
        rsp_ready = 3'b001;
        tick();
        rsp_ready = '0;
        #1;
        check("t4_still_respond", rsp_valid, 3'b100);
        check("t4_busy", busy, 1);
        rsp_ready = 3'b100;
        tick();
        rsp_ready = '0;
        #1;
        check("t4_done", busy, 0);

        // 6: stray AM valid during ISSUE (pointer at 0)
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        am_valid_i = 1'b1; am_la = 4'd7; am_da = 8'd99;
        #1;
        check("t6_am_ready_low", am_ready_o, 0);
        tick();
        am_valid_i = 1'b0;
        #1;
        check("t6_still_issue", am_valid_o, 1);
        check("t6_no_rsp", rsp_valid, 0);
        check("t6_label_unchanged", label_a, 9);
        am_ready_i = 1'b1;
        tick();
        am_ready_i = 1'b0;
        #1;
        check("t6_wait", am_ready_o, 1);

        // 5: asynchronous reset in WAIT
        req_valid = 3'b100;
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 0);
        check("t5_am_ready", am_ready_o, 0);
        check("t5_am_valid", am_valid_o, 0);
        check("t5_req_ready", req_ready, 0);
        check("t5_grant", grant_idx, 0);
        check("t5_label", label_a, 0);
        check("t5_am_hv", am_hv1, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("t5_req_ready_after", req_ready, 3'b100);
        tick();
        #1;
        check("t5_grant_after", grant_idx, 2);
        am_transact(0, 0, 4'd3, 4'd4, 8'd5, 8'd6);
        rsp_ready = 3'b100;
        req_valid = '0;
        tick();
        rsp_ready = '0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
